// File: rtl/ifmap_window_ctrl.sv
// ifmap_window_ctrl
//   Sequences the circular IFMap buffer that feeds the read-address generator.
//   A legal job config is latched from IDLE and followed by a one-cycle
//   gen_start. Input words are then admitted into the buffer while free space
//   and job words remain. The current window [start_row, end_row] slides by
//   stride on each row_adv from the generator. done pulses once no further
//   complete window fits in the job.
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   cfg_valid/cfg_ready       config handshake, ready only in IDLE
//   cfg_window, cfg_stride    words per window / window advance
//   cfg_total                 total input words in the job
//   cfg_err                   one-cycle pulse when an illegal config is offered
//   in_valid/in_ready         input word handshake
//   wr_en, wr_addr            buffer write strobe and address
//   gen_start                 one-cycle generator start pulse
//   row_adv                   generator finished the current window
//   start_row, end_row        first/last buffer entry of the current window
//   end_row_valid             every word of the current window is written
//   busy, done                job in flight / one-cycle job-finished pulse
//
// cfg_window and cfg_stride are ADDR_W+1 bits wide so that a window spanning
// the whole buffer (DEPTH = 2**ADDR_W) can be expressed.

module ifmap_window_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TOT_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W:0]   cfg_window,
  input  logic [ADDR_W:0]   cfg_stride,
  input  logic [TOT_W-1:0]  cfg_total,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              gen_start,
  input  logic              row_adv,
  output logic [ADDR_W-1:0] start_row,
  output logic [ADDR_W-1:0] end_row,
  output logic              end_row_valid,
  output logic              busy,
  output logic              done
);

  localparam int unsigned OCC_W = ADDR_W + 1;
  localparam int unsigned CMP_W = TOT_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [OCC_W-1:0]  DEPTH_O = OCC_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] wptr_q,      wptr_d;
  logic [ADDR_W-1:0] start_row_q, start_row_d;
  logic [OCC_W-1:0]  occ_q,       occ_d;
  logic [TOT_W-1:0]  base_q,      base_d;
  logic [TOT_W-1:0]  written_q,   written_d;
  logic [OCC_W-1:0]  win_q,       win_d;
  logic [OCC_W-1:0]  stride_q,    stride_d;
  logic [TOT_W-1:0]  total_q,     total_d;
  logic              gen_start_q, gen_start_d;
  logic              cfg_err_q,   cfg_err_d;

  logic              is_idle;
  logic              is_run;
  logic              cfg_legal;
  logic              win_full;
  logic              adv_fire;
  logic              adv_last;
  logic [CMP_W-1:0]  adv_sum;
  logic [OCC_W-1:0]  start_sum;
  logic [OCC_W-1:0]  end_sum;
  logic [ADDR_W-1:0] start_nxt;
  logic [ADDR_W-1:0] wptr_nxt;

  assign is_idle = (state_q == ST_IDLE);
  assign is_run  = (state_q == ST_RUN);

  // Config legality: non-zero window/stride, stride within window,
  // window fits the buffer, and the job holds at least one window.
  assign cfg_legal = (cfg_window != '0) &&
                     (cfg_stride != '0) &&
                     (cfg_stride <= cfg_window) &&
                     (cfg_window <= DEPTH_O) &&
                     (CMP_W'(cfg_total) >= CMP_W'(cfg_window));

  // Write side: space in the buffer and job words still outstanding.
  assign in_ready = is_run && (occ_q < DEPTH_O) && (written_q < total_q);
  assign wr_en    = in_valid && in_ready;
  assign wptr_nxt = (wptr_q == LAST_A) ? '0 : wptr_q + ADDR_W'(1);

  // Window state and advance.
  assign win_full      = (occ_q >= win_q);
  assign end_row_valid = is_run && win_full;
  assign adv_fire      = is_run && row_adv && win_full;

  // Widened so base + stride + window cannot overflow the compare.
  assign adv_sum  = CMP_W'(base_q) + CMP_W'(stride_q) + CMP_W'(win_q);
  assign adv_last = (adv_sum > CMP_W'(total_q));

  // Modular pointer arithmetic; both sums stay below 2*DEPTH, so a single
  // conditional subtract handles non-power-of-2 depths.
  assign start_sum = {1'b0, start_row_q} + stride_q;
  assign start_nxt = (start_sum >= DEPTH_O) ? ADDR_W'(start_sum - DEPTH_O)
                                            : ADDR_W'(start_sum);

  assign end_sum = {1'b0, start_row_q} + win_q - OCC_W'(1);

  // No job latched in IDLE, so end_row reads back as zero there.
  assign end_row = is_idle ? '0
                 : ((end_sum >= DEPTH_O) ? ADDR_W'(end_sum - DEPTH_O)
                                         : ADDR_W'(end_sum));

  assign cfg_ready = is_idle;
  assign busy      = !is_idle;
  assign done      = (state_q == ST_DONE);
  assign gen_start = gen_start_q;
  assign cfg_err   = cfg_err_q;
  assign wr_addr   = wptr_q;
  assign start_row = start_row_q;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    start_row_d = start_row_q;
    occ_d       = occ_q;
    base_d      = base_q;
    written_d   = written_q;
    win_d       = win_q;
    stride_d    = stride_q;
    total_d     = total_q;
    gen_start_d = 1'b0;
    cfg_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (cfg_legal) begin
            // Each job starts from an empty buffer at entry 0.
            win_d       = cfg_window;
            stride_d    = cfg_stride;
            total_d     = cfg_total;
            wptr_d      = '0;
            start_row_d = '0;
            occ_d       = '0;
            base_d      = '0;
            written_d   = '0;
            gen_start_d = 1'b1;
            state_d     = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        if (wr_en) begin
          wptr_d    = wptr_nxt;
          written_d = written_q + TOT_W'(1);
        end
        // The terminating advance leaves the window untouched.
        if (adv_fire && adv_last) begin
          state_d = ST_DONE;
        end else if (adv_fire) begin
          start_row_d = start_nxt;
          base_d      = base_q + TOT_W'(stride_q);
        end
        occ_d = occ_q + OCC_W'(wr_en)
              - ((adv_fire && !adv_last) ? stride_q : '0);
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      start_row_q <= '0;
      occ_q       <= '0;
      base_q      <= '0;
      written_q   <= '0;
      win_q       <= '0;
      stride_q    <= '0;
      total_q     <= '0;
      gen_start_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      start_row_q <= start_row_d;
      occ_q       <= occ_d;
      base_q      <= base_d;
      written_q   <= written_d;
      win_q       <= win_d;
      stride_q    <= stride_d;
      total_q     <= total_d;
      gen_start_q <= gen_start_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_ifmap_window_ctrl.sv
// Testbench for ifmap_window_ctrl. The reference model tracks absolute word
// positions (words written, window base) and derives buffer addresses with
// modulo arithmetic.

module tb_ifmap_window_ctrl;

  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int TOT_W  = 12;

  localparam logic [19:0] RESET_VEC = 20'h80000;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W:0]   cfg_window;
  logic [ADDR_W:0]   cfg_stride;
  logic [TOT_W-1:0]  cfg_total;
  logic              cfg_err;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              gen_start;
  logic              row_adv;
  logic [ADDR_W-1:0] start_row;
  logic [ADDR_W-1:0] end_row;
  logic              end_row_valid;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  // Reference model state: 0 idle, 1 run, 2 done.
  int m_phase, m_win, m_stride, m_total, m_base, m_written;
  bit m_gen, m_err;

  always #5 clk = ~clk;

  ifmap_window_ctrl #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TOT_W(TOT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_window(cfg_window), .cfg_stride(cfg_stride), .cfg_total(cfg_total),
    .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr),
    .gen_start(gen_start), .row_adv(row_adv),
    .start_row(start_row), .end_row(end_row), .end_row_valid(end_row_valid),
    .busy(busy), .done(done)
  );

  function automatic logic [19:0] obs_vec();
    return {cfg_ready, cfg_err, in_ready, wr_en, wr_addr, gen_start,
            start_row, end_row, end_row_valid, busy, done};
  endfunction

  function automatic logic [19:0] exp_vec();
    int occ;
    logic irdy, erv;
    logic [3:0] wa, sr, er;
    occ  = m_written - m_base;
    irdy = (m_phase == 1) && (occ < DEPTH) && (m_written < m_total);
    erv  = (m_phase == 1) && (occ >= m_win);
    wa   = 4'(m_written % DEPTH);
    sr   = 4'(m_base % DEPTH);
    er   = (m_phase == 0) ? 4'd0 : 4'((m_base + m_win - 1) % DEPTH);
    return {(m_phase == 0), m_err, irdy, in_valid & irdy, wa, m_gen,
            sr, er, erv, (m_phase != 0), (m_phase == 2)};
  endfunction

  task automatic model_reset();
    m_phase = 0; m_base = 0; m_written = 0; m_gen = 0; m_err = 0;
  endtask

  // Applies the effect of the coming clock edge given the current inputs.
  task automatic model_advance();
    int occ, w, s, t;
    bit irdy, nerr, ngen;
    occ  = m_written - m_base;
    irdy = (m_phase == 1) && (occ < DEPTH) && (m_written < m_total);
    nerr = 0;
    ngen = 0;
    w = int'(cfg_window);
    s = int'(cfg_stride);
    t = int'(cfg_total);
    case (m_phase)
      0: if (cfg_valid) begin
        if (w >= 1 && s >= 1 && s <= w && w <= DEPTH && t >= w) begin
          m_win = w; m_stride = s; m_total = t;
          m_base = 0; m_written = 0; ngen = 1; m_phase = 1;
        end else begin
          nerr = 1;
        end
      end
      1: begin
        if (row_adv && occ >= m_win) begin
          if (m_base + m_stride + m_win > m_total) m_phase = 2;
          else m_base = m_base + m_stride;
        end
        if (in_valid && irdy) m_written = m_written + 1;
      end
      2: m_phase = 0;
      default: m_phase = 0;
    endcase
    m_gen = ngen;
    m_err = nerr;
  endtask

  task automatic step();
    model_advance();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cfg_valid = 1'b0;
    in_valid  = 1'b0;
    row_adv   = 1'b0;
  endtask

  task automatic set_cfg(input int w, input int s, input int t);
    cfg_window = 5'(w);
    cfg_stride = 5'(s);
    cfg_total  = 12'(t);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    set_cfg(3, 1, 6);
    cfg_valid = 1'b1;
    in_valid  = 1'b1;
    row_adv   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_held: got %h want %h", obs_vec(), RESET_VEC);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_release: got %h want %h", obs_vec(), exp_vec());
    end
    step();
    #1;
    checks++;
    if (gen_start !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_accept: gen_start=%b busy=%b want 1 1", gen_start, busy);
    end
    do_reset();
  endtask

  task automatic test_basic_window();
    logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd2, 4'd3};
    logic [3:0] exp_e [4] = '{4'd2, 4'd3, 4'd4, 4'd5};
    logic [3:0] got_s [$];
    logic [3:0] got_e [$];
    int writes = 0;
    bit saw_valid = 0, saw_done = 0;
    set_cfg(3, 1, 6);
    cfg_valid = 1'b1;
    #1;
    step();
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    row_adv   = 1'b1;
    for (int c = 0; c < 40; c++) begin
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL basic_cycle%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (end_row_valid && !saw_valid) begin
        saw_valid = 1;
        checks++;
        if (writes !== 3) begin
          failures++;
          $display("FAIL basic_first_valid: writes=%0d want 3", writes);
        end
      end
      if (end_row_valid) begin
        got_s.push_back(start_row);
        got_e.push_back(end_row);
      end
      if (done) saw_done = 1;
      if (wr_en) writes++;
      step();
      if (saw_done) break;
    end
    in_valid = 1'b0;
    row_adv  = 1'b0;
    #1;
    checks++;
    if (!saw_done || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done: saw_done=%0d busy=%b want 1 0", saw_done, busy);
    end
    checks++;
    if (got_s.size() != 4) begin
      failures++;
      $display("FAIL basic_windows: count=%0d want 4", got_s.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_s[i] !== exp_s[i] || got_e[i] !== exp_e[i]) begin
          failures++;
          $display("FAIL basic_window%0d: got (%0d,%0d) want (%0d,%0d)",
                   i, got_s[i], got_e[i], exp_s[i], exp_e[i]);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_full_buffer();
    set_cfg(16, 4, 40);
    cfg_valid = 1'b1;
    #1;
    step();
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++;
      if (wr_en !== 1'b1 || wr_addr !== 4'(i) || obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL full_write%0d: wr_en=%b wr_addr=%0d vec=%h want 1 %0d vec=%h",
                 i, wr_en, wr_addr, obs_vec(), i, exp_vec());
      end
      step();
    end
    #1;
    checks++;
    if (in_ready !== 1'b0 || end_row_valid !== 1'b1) begin
      failures++;
      $display("FAIL full_block: in_ready=%b end_row_valid=%b want 0 1", in_ready, end_row_valid);
    end
    row_adv = 1'b1;
    step();
    row_adv = 1'b0;
    #1;
    checks++;
    if (start_row !== 4'd4 || in_ready !== 1'b1 || end_row_valid !== 1'b0 ||
        wr_en !== 1'b1 || wr_addr !== 4'd0) begin
      failures++;
      $display("FAIL full_release: start=%0d in_ready=%b erv=%b wr_en=%b wr_addr=%0d want 4 1 0 1 0",
               start_row, in_ready, end_row_valid, wr_en, wr_addr);
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL full_release_vec: got %h want %h", obs_vec(), exp_vec());
    end
    step();
    do_reset();
  endtask

  task automatic test_simultaneous();
    set_cfg(5, 2, 20);
    cfg_valid = 1'b1;
    #1;
    step();
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    repeat (5) begin
      #1;
      step();
    end
    row_adv = 1'b1;
    #1;
    checks++;
    if (end_row_valid !== 1'b1 || wr_en !== 1'b1) begin
      failures++;
      $display("FAIL simul_setup: erv=%b wr_en=%b want 1 1", end_row_valid, wr_en);
    end
    step();
    row_adv  = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (end_row_valid !== 1'b0 || start_row !== 4'd2 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL simul_after: erv=%b start=%0d vec=%h want 0 2 vec=%h",
               end_row_valid, start_row, obs_vec(), exp_vec());
    end
    do_reset();
  endtask

  task automatic test_illegal();
    int ws [2] = '{3, 3};
    int ss [2] = '{4, 1};
    int ts [2] = '{10, 2};
    for (int k = 0; k < 2; k++) begin
      set_cfg(ws[k], ss[k], ts[k]);
      cfg_valid = 1'b1;
      #1;
      step();
      cfg_valid = 1'b0;
      #1;
      checks++;
      if (cfg_err !== 1'b1 || busy !== 1'b0 || gen_start !== 1'b0 || obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL illegal%0d_pulse: cfg_err=%b busy=%b gen_start=%b want 1 0 0",
                 k, cfg_err, busy, gen_start);
      end
      step();
      #1;
      checks++;
      if (cfg_err !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL illegal%0d_after: cfg_err=%b busy=%b want 0 0", k, cfg_err, busy);
      end
    end
  endtask

  task automatic test_random_jobs();
    int w, s, t, kind;
    for (int j = 0; j < 30; j++) begin
      idle_inputs();
      w = int'($urandom_range(1, 16));
      s = int'($urandom_range(1, w));
      t = w + int'($urandom_range(0, 30));
      if ($urandom_range(0, 7) == 0) begin
        kind = int'($urandom_range(0, 4));
        case (kind)
          0: w = 0;
          1: s = 0;
          2: s = w + 1;
          3: w = 17;
          default: t = w - 1;
        endcase
      end
      set_cfg(w, s, t);
      cfg_valid = 1'b1;
      #1;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rand%0d_offer: got %h want %h", j, obs_vec(), exp_vec());
      end
      step();
      cfg_valid = 1'b0;
      for (int c = 0; c < 800; c++) begin
        in_valid = ($urandom_range(0, 3) != 0);
        row_adv  = ($urandom_range(0, 2) == 0);
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
          failures++;
          $display("FAIL rand%0d_cycle%0d: got %h want %h", j, c, obs_vec(), exp_vec());
        end
        step();
        if (m_phase == 0) break;
      end
      checks++;
      if (m_phase != 0) begin
        failures++;
        $display("FAIL rand%0d_timeout: job still active, phase=%0d want 0", j, m_phase);
        do_reset();
      end
    end
    idle_inputs();
  endtask

  task automatic test_mid_reset();
    set_cfg(3, 1, 40);
    cfg_valid = 1'b1;
    #1;
    step();
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    row_adv   = 1'b1;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (m_base == 7) break;
      step();
    end
    checks++;
    if (start_row !== 4'd7 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_setup: start=%0d busy=%b want 7 1", start_row, busy);
    end
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL midrst_immediate: got %h want %h", obs_vec(), RESET_VEC);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || obs_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL midrst_held: done=%b vec=%h want 0 %h", done, obs_vec(), RESET_VEC);
    end
    rst = 1'b0;
    idle_inputs();
    set_cfg(3, 1, 6);
    cfg_valid = 1'b1;
    #1;
    step();
    cfg_valid = 1'b0;
    in_valid  = 1'b1;
    #1;
    checks++;
    if (wr_en !== 1'b1 || wr_addr !== 4'd0 || obs_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL midrst_newjob: wr_en=%b wr_addr=%0d want 1 0", wr_en, wr_addr);
    end
    step();
    do_reset();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    set_cfg(0, 0, 0);
    model_reset();
    m_win = 0; m_stride = 0; m_total = 0;
    test_reset();
    test_basic_window();
    test_full_buffer();
    test_simultaneous();
    test_illegal();
    test_random_jobs();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
